// File: rtl/inst_trace_buffer_pkg.sv
// Shared record layout and widths for the instruction trace buffer.
package inst_trace_buffer_pkg;

  localparam int TRACE_REC_W   = 64;
  localparam int PC_W          = 32;
  localparam int INSTR_W       = 32;
  localparam int REC_PC_LSB    = 32;
  localparam int REC_INSTR_LSB = 0;
  localparam int DROP_CNT_W    = 16;

  // Packed so that pc lands in [63:32] and instr in [31:0].
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } trace_rec_t;

  function automatic logic [TRACE_REC_W-1:0] pack_rec(input logic [PC_W-1:0]    pc,
                                                      input logic [INSTR_W-1:0] instr);
    trace_rec_t r;
    r.pc    = pc;
    r.instr = instr;
    return r;
  endfunction

endpackage

// File: rtl/inst_trace_buffer_if.sv
// Valid/ready readout port carrying one {pc, instr} record per handshake.
interface inst_trace_buffer_if;
  import inst_trace_buffer_pkg::*;

  logic               rd_valid;
  logic               rd_ready;
  logic [PC_W-1:0]    rd_pc;
  logic [INSTR_W-1:0] rd_instr;

  // The buffer sources records; the debug bridge consumes them.
  modport master (output rd_valid, output rd_pc, output rd_instr, input rd_ready);
  modport slave  (input rd_valid, input rd_pc, input rd_instr, output rd_ready);

endinterface

// File: rtl/inst_trace_buffer_mem.sv
// DEPTH x 64 record storage: one synchronous write port, one asynchronous read port.
module trace_fifo_mem
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [TRACE_REC_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [TRACE_REC_W-1:0] rdata
);

  logic [TRACE_REC_W-1:0] mem [DEPTH];

  // Write the incoming record; the array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer: captures {pc, instr} records from the core fetch
// stage into a show-ahead FIFO drained over a valid/ready port, with dedup of
// repeated pcs and a sticky overflow flag plus saturating drop counter.
module inst_trace_buffer
  import inst_trace_buffer_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  DEDUP = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cap_en,
  input  logic [PC_W-1:0]       pc,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  flush,
  inst_trace_buffer_if.master   rd,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [PC_W-1:0]        last_pc;
  logic                   last_pc_vld;
  logic                   dup;
  logic                   cap;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [TRACE_REC_W-1:0] head_rec;

  // Dedup compares against the last offered pc, whether it was stored or dropped.
  assign dup  = (DEDUP != 0) && last_pc_vld && (pc == last_pc);
  assign cap  = cap_en && !dup;
  // Flush discards everything offered that cycle, so it masks push, pop and drop.
  assign pop  = !flush && rd.rd_valid && rd.rd_ready;
  assign push = !flush && cap && ((count != FULL_CNT) || pop);
  assign drop = !flush && cap && !push;

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (pack_rec(pc, instr)),
    .raddr (rd_ptr),
    .rdata (head_rec)
  );

  // Pointer and occupancy control; count alone separates full from empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Loss accounting: sticky overflow and a drop counter that holds at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Validity of the remembered pc; cleared so the first offer after flush is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       last_pc_vld <= 1'b0;
    else if (flush)  last_pc_vld <= 1'b0;
    else if (cap_en) last_pc_vld <= 1'b1;
  end

  // Remembered pc value; only meaningful while last_pc_vld is set.
  always_ff @(posedge clk) begin
    if (cap_en) last_pc <= pc;
  end

  // Show-ahead head; forced to zero when empty so reset leaves the outputs at 0.
  assign rd.rd_valid = (count != '0);
  assign rd.rd_pc    = rd.rd_valid ? head_rec[REC_PC_LSB +: PC_W]       : '0;
  assign rd.rd_instr = rd.rd_valid ? head_rec[REC_INSTR_LSB +: INSTR_W] : '0;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: a DEPTH=4 instance driven from a vector table,
// and a DEPTH=16 instance streamed against a queue scoreboard for pointer wrap.
module tb_inst_trace_buffer;
  import inst_trace_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        rstn4, cap4, fl4;
  logic [31:0] pc4, ins4;
  logic [2:0]  count4;
  logic        ovf4;
  logic [15:0] drop4;
  inst_trace_buffer_if if4 ();

  inst_trace_buffer #(.DEPTH(4), .DEDUP(1)) u_d4 (
    .clk(clk), .rstn(rstn4), .cap_en(cap4), .pc(pc4), .instr(ins4), .flush(fl4),
    .rd(if4), .count(count4), .overflow(ovf4), .drop_cnt(drop4)
  );

  // DEPTH=16 instance
  logic        rstn16, cap16, fl16;
  logic [31:0] pc16, ins16;
  logic [4:0]  count16;
  logic        ovf16;
  logic [15:0] drop16;
  inst_trace_buffer_if if16 ();

  inst_trace_buffer #(.DEPTH(16), .DEDUP(1)) u_d16 (
    .clk(clk), .rstn(rstn16), .cap_en(cap16), .pc(pc16), .instr(ins16), .flush(fl16),
    .rd(if16), .count(count16), .overflow(ovf16), .drop_cnt(drop16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        cap;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        rdy;
    logic        fl;
    int          cnt;
    logic        vld;
    logic [31:0] hpc;
    logic [31:0] hins;
    logic        ovf;
    int          drop;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] xi(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic cap, input logic [31:0] pc, input logic [31:0] ins,
                              input logic rdy, input logic fl, input int cnt, input logic vld,
                              input logic [31:0] hpc, input logic [31:0] hins,
                              input logic ovf, input int drop);
    vec_t v;
    v.cap = cap; v.pc = pc; v.ins = ins; v.rdy = rdy; v.fl = fl;
    v.cnt = cnt; v.vld = vld; v.hpc = hpc; v.hins = hins; v.ovf = ovf; v.drop = drop;
    return v;
  endfunction

  initial begin
    int sent, popped, mdrops, cyc;
    logic c, r;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] p;

    rstn4 = 1'b0; cap4 = 1'b0; fl4 = 1'b0; pc4 = '0; ins4 = '0; if4.rd_ready = 1'b0;
    rstn16 = 1'b0; cap16 = 1'b0; fl16 = 1'b0; pc16 = '0; ins16 = '0; if16.rd_ready = 1'b0;

    // Basic capture and drain
    tbl.push_back(mk(1, 32'h0, 32'h20080005, 0, 0, 1, 1, 32'h0, 32'h20080005, 0, 0));
    tbl.push_back(mk(1, 32'h4, 32'h20090003, 0, 0, 2, 1, 32'h0, 32'h20080005, 0, 0));
    tbl.push_back(mk(1, 32'h8, 32'h01095020, 0, 0, 3, 1, 32'h0, 32'h20080005, 0, 0));
    tbl.push_back(mk(0, 32'h0, 32'h0,        1, 0, 2, 1, 32'h4, 32'h20090003, 0, 0));
    tbl.push_back(mk(0, 32'h0, 32'h0,        1, 0, 1, 1, 32'h8, 32'h01095020, 0, 0));
    tbl.push_back(mk(0, 32'h0, 32'h0,        1, 0, 0, 0, 32'h0, 32'h0,        0, 0));
    // Dedup: pc 0x10 held five cycles, then 0x14
    tbl.push_back(mk(1, 32'h10, xi(32'h10), 0, 0, 1, 1, 32'h10, xi(32'h10), 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 32'h10, 32'hDEAD_0000, 0, 0, 1, 1, 32'h10, xi(32'h10), 0, 0));
    tbl.push_back(mk(1, 32'h14, xi(32'h14), 0, 0, 2, 1, 32'h10, xi(32'h10), 0, 0));
    tbl.push_back(mk(0, 32'h0,  32'h0,      1, 0, 1, 1, 32'h14, xi(32'h14), 0, 0));
    tbl.push_back(mk(0, 32'h0,  32'h0,      1, 0, 0, 0, 32'h0,  32'h0,      0, 0));
    // Overflow: six distinct pcs into four slots
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 32'h100 + 32'(4*i), xi(32'h100 + 32'(4*i)), 0, 0,
                       i+1, 1, 32'h100, xi(32'h100), 0, 0));
    tbl.push_back(mk(1, 32'h110, xi(32'h110), 0, 0, 4, 1, 32'h100, xi(32'h100), 1, 1));
    tbl.push_back(mk(1, 32'h114, xi(32'h114), 0, 0, 4, 1, 32'h100, xi(32'h100), 1, 2));
    // Same pc as the last dropped offer is suppressed, not counted again
    tbl.push_back(mk(1, 32'h114, xi(32'h114), 0, 0, 4, 1, 32'h100, xi(32'h100), 1, 2));
    // Full with simultaneous pop accepts the new record
    tbl.push_back(mk(1, 32'h118, xi(32'h118), 1, 0, 4, 1, 32'h104, xi(32'h104), 1, 2));
    tbl.push_back(mk(0, 32'h0, 32'h0, 1, 0, 3, 1, 32'h108, xi(32'h108), 1, 2));
    tbl.push_back(mk(0, 32'h0, 32'h0, 1, 0, 2, 1, 32'h10C, xi(32'h10C), 1, 2));
    tbl.push_back(mk(0, 32'h0, 32'h0, 1, 0, 1, 1, 32'h118, xi(32'h118), 1, 2));
    tbl.push_back(mk(0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0,   32'h0,       1, 2));
    // Flush with cap and rd_ready active in the same cycle
    tbl.push_back(mk(1, 32'h200, xi(32'h200), 0, 0, 1, 1, 32'h200, xi(32'h200), 1, 2));
    tbl.push_back(mk(1, 32'h204, xi(32'h204), 0, 0, 2, 1, 32'h200, xi(32'h200), 1, 2));
    tbl.push_back(mk(1, 32'h208, xi(32'h208), 1, 1, 0, 0, 32'h0,   32'h0,       0, 0));
    tbl.push_back(mk(1, 32'h208, xi(32'h208), 0, 0, 1, 1, 32'h208, xi(32'h208), 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,       1, 0, 0, 0, 32'h0,   32'h0,       0, 0));

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    check("rst count4", 64'(count4), 64'd0);
    check("rst vld4", 64'(if4.rd_valid), 64'd0);
    check("rst pc4", 64'(if4.rd_pc), 64'd0);
    check("rst instr4", 64'(if4.rd_instr), 64'd0);
    check("rst ovf4", 64'(ovf4), 64'd0);
    check("rst drop4", 64'(drop4), 64'd0);
    check("rst count16", 64'(count16), 64'd0);
    check("rst vld16", 64'(if16.rd_valid), 64'd0);
    rstn4 = 1'b1; rstn16 = 1'b1;

    // Table-driven vectors on the DEPTH=4 instance
    foreach (tbl[i]) begin
      cap4 = tbl[i].cap; pc4 = tbl[i].pc; ins4 = tbl[i].ins;
      if4.rd_ready = tbl[i].rdy; fl4 = tbl[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", i), 64'(count4), 64'(tbl[i].cnt));
      check($sformatf("v%0d valid", i), 64'(if4.rd_valid), 64'(tbl[i].vld));
      check($sformatf("v%0d overflow", i), 64'(ovf4), 64'(tbl[i].ovf));
      check($sformatf("v%0d drop_cnt", i), 64'(drop4), 64'(tbl[i].drop));
      if (tbl[i].vld) begin
        check($sformatf("v%0d head_pc", i), 64'(if4.rd_pc), 64'(tbl[i].hpc));
        check($sformatf("v%0d head_instr", i), 64'(if4.rd_instr), 64'(tbl[i].hins));
      end
    end

    // Asynchronous reset during a drain
    cap4 = 1'b1; pc4 = 32'h400; ins4 = xi(32'h400); if4.rd_ready = 1'b0; fl4 = 1'b0;
    @(posedge clk); #1;
    pc4 = 32'h404; ins4 = xi(32'h404);
    @(posedge clk); #1;
    cap4 = 1'b0;
    check("pre-rst count", 64'(count4), 64'd2);
    check("pre-rst head", 64'(if4.rd_pc), 64'h400);
    // Hold the head while not ready, then raise ready and reset mid-cycle
    @(posedge clk); #1;
    check("stall head", 64'(if4.rd_pc), 64'h400);
    if4.rd_ready = 1'b1;
    #2;
    rstn4 = 1'b0;
    #1;
    check("async rst valid", 64'(if4.rd_valid), 64'd0);
    check("async rst count", 64'(count4), 64'd0);
    #3;
    rstn4 = 1'b1;
    @(posedge clk); #1;
    check("post-rst count", 64'(count4), 64'd0);
    check("post-rst valid", 64'(if4.rd_valid), 64'd0);

    // Pointer wrap: 40 records through the DEPTH=16 instance
    sent = 0; popped = 0; mdrops = 0; cyc = 0;
    while ((sent < 40 || q_pc.size() > 0) && cyc < 400) begin
      c = (sent < 40) && ((cyc < 14) || (cyc % 2 == 0));
      r = (cyc >= 14) && ((cyc % 2 == 1) || (sent >= 40));
      p = 32'h1000 + 32'(4*sent);
      cap16 = c; pc16 = p; ins16 = ~p; if16.rd_ready = r;
      if (r && q_pc.size() > 0) begin
        check($sformatf("wrap pop%0d valid", popped), 64'(if16.rd_valid), 64'd1);
        check($sformatf("wrap pop%0d pc", popped), 64'(if16.rd_pc), 64'(q_pc[0]));
        check($sformatf("wrap pop%0d instr", popped), 64'(if16.rd_instr), 64'(q_in[0]));
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
        popped++;
      end
      if (c) begin
        if (q_pc.size() < 16) begin
          q_pc.push_back(p);
          q_in.push_back(~p);
        end else begin
          mdrops++;
        end
        sent++;
      end
      @(posedge clk);
      #1;
      check($sformatf("wrap cyc%0d count", cyc), 64'(count16), 64'(q_pc.size()));
      cyc++;
    end
    cap16 = 1'b0; if16.rd_ready = 1'b0;
    check("wrap drained", 64'(popped), 64'd40);
    check("wrap drop_cnt", 64'(drop16), 64'(mdrops));
    check("wrap no drops", 64'(mdrops), 64'd0);
    check("wrap overflow", 64'(ovf16), 64'd0);
    check("wrap empty", 64'(if16.rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_trace_buffer.md
Name: inst_trace_buffer

Overview:
- Downstream debug consumer of the single-cycle core's fetch outputs (pc, Instruction).
- Captures one {pc, instruction} record per enabled clock into an on-chip FIFO.
- Records drain through a valid/ready port to a debug readout (UART/JTAG bridge).
- Provides a sticky overflow flag and a saturating drop counter so lost records are accounted for.

Parameters:
- DEPTH, 16, number of records; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- DEDUP, 1, when 1 suppress a record whose pc equals the last captured pc.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- cap_en  in  1  capture enable, sampled every clk.
- pc  in  32  current core pc.
- instr  in  32  instruction fetched at pc.
- flush  in  1  synchronous clear of FIFO, flags and counters.
- rd_valid  out  1  head record available.
- rd_ready  in  1  consumer accepts head record.
- rd_pc  out  32  head record pc.
- rd_instr  out  32  head record instruction.
- count  out  AW+1  records currently stored.
- overflow  out  1  sticky: at least one record was dropped.
- drop_cnt  out  16  dropped records, saturating at 16'hFFFF.

Behaviour:
- Reset (rstn=0, async):
  - wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_pc=0, rd_instr=0, overflow=0, drop_cnt=0.
  - last_pc_vld=0.
  - Storage array is not reset.
- Capture request (cap):
  - cap = cap_en && !(DEDUP && last_pc_vld && pc==last_pc).
  - last_pc and last_pc_vld=1 update on every cycle where cap_en=1 and the record is kept or dropped. Dedup therefore compares against the last offered pc, not the last stored one.
- Pop:
  - pop = rd_valid && rd_ready.
  - pop advances rd_ptr; count decrements.
- Push:
  - push = cap && (count<DEPTH || pop). Full-with-simultaneous-pop accepts the new record.
  - push writes {pc,instr} at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on both.
- Drop:
  - drop = cap && !push.
  - overflow <= 1 (sticky until flush/reset); drop_cnt increments, holds at 16'hFFFF.
- Read port:
  - Show-ahead: rd_pc and rd_instr present the mem[rd_ptr] entry whenever rd_valid=1.
  - Values are undefined (not checked) when rd_valid=0.
  - rd_valid = (count!=0).
  - Latency: a record pushed at edge N is visible at the head after edge N if the FIFO was empty.
  - rd_pc/rd_instr must hold stable while rd_valid=1 && rd_ready=0.
- Pointers: wr_ptr and rd_ptr are AW bits wide and wrap naturally. count distinguishes full from empty.
- Flush:
  - Effective on the clock edge; same clearing as reset, except the array is untouched.
  - Overrides push/pop in the same cycle: the record offered that cycle is discarded and not counted as a drop.
- Reset mid-readout: the in-flight handshake is abandoned; rd_valid is 0 immediately (async).
- No combinational path from rd_ready to rd_valid.

Decomposition:
- Shared package:
  - TRACE_REC_W = 64.
  - Record field offsets: pc in bits [63:32], instr in bits [31:0].
  - DROP_CNT_W = 16.
- One natural sub-module: trace_fifo_mem, a DEPTH x 64 storage array with one write port and one asynchronous read port.
- Pointer, count and flag control stays in inst_trace_buffer.

Test Plan:
- Basic capture and drain:
  - Stimulus: reset, cap_en=1 for 3 cycles with pc=0x0,0x4,0x8 and instr=0x20080005,0x20090003,0x01095020, rd_ready=0.
  - Required: count=3, rd_valid=1, head pc=0x0.
  - Then rd_ready=1: records pop in order, and count=0 after 3 pops.
- Dedup:
  - Stimulus: DEDUP=1, pc held at 0x10 for 5 cycles with cap_en=1, then pc=0x14.
  - Required: exactly 2 records stored (0x10, 0x14); drop_cnt=0.
- Overflow, DEPTH=4:
  - Stimulus: 6 distinct pcs captured with rd_ready=0.
  - Required: count=4, overflow=1, drop_cnt=2; drained pcs are the first 4 in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full, rd_ready=1 and cap with a new pc in the same cycle.
  - Required: count stays 4, drop_cnt unchanged, the new pc becomes the tail record.
- Flush and reset:
  - Stimulus: flush asserted with FIFO holding records, cap and rd_ready active in the same cycle.
  - Required: next cycle count=0, rd_valid=0, overflow=0, drop_cnt=0.
  - Stimulus: rstn pulsed low mid-clock during drain.
  - Required: rd_valid falls immediately, without waiting for a clock edge.
- Pointer wrap:
  - Stimulus: 40 records streamed through DEPTH=16 with rd_ready toggling.
  - Required: output sequence equals input sequence, and no drops while count<16.
